aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/aes_decrypt_iter_if.sv | 24 ++
 rtl/aes_inv_round.sv | 39 +++
 rtl/aes_decrypt_iter.sv | 139 +++++++++++++
 tb/tb_aes_decrypt_iter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, FSM state type, S-box tables,
// round-constant function and GF(2^8) helpers (modulo x^8+x^4+x^3+x+1).
package aes_pkg;

    localparam int unsigned AES_NR = 10;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Round constant for schedule step i (1..10); other indices are unused.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Job handshake bundle for aes_decrypt_iter.
//   in_valid/in_ready/data_in/key : ciphertext + key offer
//   out_valid/out_ready/data_out  : plaintext hand-off
//   busy                          : engine not idle
interface aes_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, key, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, key, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
//   state_in  : 128-bit state, byte 0 in [127:120], column-major
//   round_key : round key applied in this round
//   last      : skip InvMixColumns (final round)
//   state_out : resulting state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);
    logic [7:0] b [16];

    always_comb begin
        // Row r is rotated right by r: output column c takes input column c-r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[r + 4*c] = INV_SBOX[state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]]
                             ^ round_key[127 - 8*(r + 4*c) -: 8];
            end
        end
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                state_out[127 - 32*c -: 32] = {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]};
            end else begin
                state_out[127 - 32*c -: 32] = {
                    gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09),
                    gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d),
                    gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b),
                    gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e)
                };
            end
        end
    end
endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock, with a single-entry
// cache of the last expanded key so repeated keys skip the forward schedule.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : job handshake (slave side), see aes_decrypt_iter_if
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned Nr = AES_NR
) (
    input logic         clk,
    input logic         reset,
    aes_decrypt_iter_if.slave bus
);
    aes_state_e   st;
    logic [3:0]   cnt;
    logic [3:0]   r;
    logic [127:0] ct_q;
    logic [127:0] key_q;
    logic [127:0] state_q;
    logic [127:0] data_out_q;
    logic [127:0] key_cache;
    logic [127:0] rk10_cache;
    logic         cache_valid;
    logic         out_valid_q;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;
    logic [127:0] round_out;
    logic         accept;
    logic         hit;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one schedule step; order matters so each word uses its old neighbour.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    assign fwd_key = fwd_step(key_q, rcon(cnt));
    assign inv_key = inv_step(key_q, rcon(r + 4'd1));
    assign accept  = bus.in_valid && (st == IDLE);
    assign hit     = cache_valid && (bus.key == key_cache);

    aes_inv_round u_inv_round (
        .state_in  (state_q),
        .round_key (inv_key),
        .last      (r == 4'd0),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            cnt         <= 4'd0;
            r           <= 4'd0;
            ct_q        <= '0;
            key_q       <= '0;
            state_q     <= '0;
            data_out_q  <= '0;
            key_cache   <= '0;
            rk10_cache  <= '0;
            cache_valid <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            state_q <= bus.data_in ^ rk10_cache;
                            key_q   <= rk10_cache;
                            r       <= 4'(Nr - 1);
                            st      <= ROUND;
                        end else begin
                            // Cache entry is rebuilt by this job; invalid until rk10 is known.
                            ct_q        <= bus.data_in;
                            key_q       <= bus.key;
                            key_cache   <= bus.key;
                            cache_valid <= 1'b0;
                            cnt         <= 4'd1;
                            st          <= KEYEXP;
                        end
                    end
                end
                KEYEXP: begin
                    key_q <= fwd_key;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'(Nr)) begin
                        state_q     <= ct_q ^ fwd_key;
                        rk10_cache  <= fwd_key;
                        cache_valid <= 1'b1;
                        cnt         <= 4'd0;
                        r           <= 4'(Nr - 1);
                        st          <= ROUND;
                    end
                end
                ROUND: begin
                    key_q   <= inv_key;
                    state_q <= round_out;
                    r       <= r - 4'd1;
                    if (r == 4'd0) begin
                        data_out_q  <= round_out;
                        out_valid_q <= 1'b1;
                        r           <= 4'd0;
                        st          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        st          <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (st == IDLE);
    assign bus.busy      = (st != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;
    logic clk;
    logic reset;
    aes_decrypt_iter_if bus ();

    aes_decrypt_iter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference AES built from field arithmetic ----------------
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sboxes();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) begin
            tmp = w[40 + b/4];
            s[b] = ct[127 - 8*b -: 8] ^ tmp[31 - 8*(b%4) -: 8];
        end
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*((c + r) % 4)] = s[r + 4*c];
            for (int b = 0; b < 16; b++) begin
                tmp = w[4*rnd + b/4];
                s[b] = isb[t[b]] ^ tmp[31 - 8*(b%4) -: 8];
            end
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
                    s[4*c+0] = gf_mul(a[0], 8'h0e) ^ gf_mul(a[1], 8'h0b) ^ gf_mul(a[2], 8'h0d) ^ gf_mul(a[3], 8'h09);
                    s[4*c+1] = gf_mul(a[0], 8'h09) ^ gf_mul(a[1], 8'h0e) ^ gf_mul(a[2], 8'h0b) ^ gf_mul(a[3], 8'h0d);
                    s[4*c+2] = gf_mul(a[0], 8'h0d) ^ gf_mul(a[1], 8'h09) ^ gf_mul(a[2], 8'h0e) ^ gf_mul(a[3], 8'h0b);
                    s[4*c+3] = gf_mul(a[0], 8'h0b) ^ gf_mul(a[1], 8'h0d) ^ gf_mul(a[2], 8'h09) ^ gf_mul(a[3], 8'h0e);
                end
            end
        end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    // ---------------- transaction-level timing model ----------------
    // phase 0 idle, 1 working, 2 result held; remaining = edges until result.
    int           m_phase;
    int           m_remaining;
    logic [127:0] m_pt;
    logic [127:0] m_dout;
    logic [127:0] m_cache_key;
    logic         m_cache_valid;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase       <= 0;
            m_remaining   <= 0;
            m_dout        <= '0;
            m_cache_valid <= 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_pt          <= model_decrypt(bus.data_in, bus.key);
                    m_remaining   <= (m_cache_valid && bus.key == m_cache_key) ? 10 : 20;
                    m_cache_key   <= bus.key;
                    m_cache_valid <= 1'b1;
                    m_phase       <= 1;
                end
                1: begin
                    m_remaining <= m_remaining - 1;
                    if (m_remaining == 1) begin
                        m_phase <= 2;
                        m_dout  <= m_pt;
                    end
                end
                default: if (bus.out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc in_ready",  {127'd0, bus.in_ready},  {127'd0, m_phase == 0});
            check("cyc busy",      {127'd0, bus.busy},      {127'd0, m_phase != 0});
            check("cyc out_valid", {127'd0, bus.out_valid}, {127'd0, m_phase == 2});
            check("cyc data_out",  bus.data_out, m_dout);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic run_job(input string name, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] exp_pt, input int exp_lat, input int hold,
                           input bit scramble);
        int lat;
        check({name, " idle before"}, {127'd0, bus.in_ready}, 128'd1);
        bus.in_valid = 1'b1;
        bus.data_in  = ct;
        bus.key      = k;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (scramble) begin
            bus.data_in = ~ct;
            bus.key     = KEY1 ^ k ^ 128'h5a;
        end
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(exp_lat));
        check({name, " plaintext"}, bus.data_out, exp_pt);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 128'hdeadbeef ^ 128'(i);
            @(posedge clk);
            #1;
            check({name, " hold out_valid"}, {127'd0, bus.out_valid}, 128'd1);
            check({name, " hold data_out"}, bus.data_out, exp_pt);
            check({name, " hold in_ready"}, {127'd0, bus.in_ready}, 128'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({name, " released"}, {126'd0, bus.out_valid, bus.busy}, 128'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        bus.key       = '0;
        reset         = 1'b0;
        build_sboxes();
        check("model FIPS C.1", model_decrypt(CT1, KEY1), PT1);
        check("model FIPS B",   model_decrypt(CT2, KEY2), PT2);
        #3 reset = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset outputs", {125'd0, bus.in_ready, bus.out_valid, bus.busy}, 128'd4);
        check("reset data_out", bus.data_out, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        run_job("miss key1", CT1, KEY1, PT1, 20, 0, 1'b0);
        run_job("hit key1",  CT1, KEY1, PT1, 10, 0, 1'b0);
        check("rk10_cache", dut.rk10_cache, RK10);
        run_job("miss key2 scrambled", CT2, KEY2, PT2, 20, 0, 1'b1);
        run_job("hit key2 hold", CT2, KEY2, PT2, 10, 5, 1'b0);

        // Abort a key-expansion run with reset.
        bus.in_valid = 1'b1;
        bus.data_in  = CT1;
        bus.key      = KEY1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort outputs", {125'd0, bus.in_ready, bus.out_valid, bus.busy}, 128'd4);
        check("abort data_out", bus.data_out, 128'd0);
        check("abort cache_valid", {127'd0, dut.cache_valid}, 128'd0);
        check("abort cnt/r", {120'd0, dut.cnt, dut.r}, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        run_job("post-abort miss", CT1, KEY1, PT1, 20, 0, 1'b0);
        run_job("post-abort hit",  CT1, KEY1, PT1, 10, 0, 1'b0);

        // Idle reset must drop the cache.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        run_job("post-reset miss", CT1, KEY1, PT1, 20, 2, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
